// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data words, register numbers, ALU operations and PC select encodings.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pcsel_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: 32-bit result plus zero flag; shifts use opB[4:0], overflow ignored.
module ex_alu
    import cpu_types_pkg::*;
(
    input  word_t  opA,
    input  word_t  opB,
    input  aluop_t ALUop,
    output word_t  out,
    output logic   zero
);

    always_comb begin
        out = '0;
        case (ALUop)
            ALU_SLL:  out = opA << opB[4:0];
            ALU_SRL:  out = opA >> opB[4:0];
            ALU_ADD:  out = opA + opB;
            ALU_SUB:  out = opA - opB;
            ALU_AND:  out = opA & opB;
            ALU_OR:   out = opA | opB;
            ALU_XOR:  out = opA ^ opB;
            ALU_NOR:  out = ~(opA | opB);
            ALU_SLT:  out = {31'b0, ($signed(opA) < $signed(opB))};
            ALU_SLTU: out = {31'b0, (opA < opB)};
            default:  out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect and the EX/MEM pipeline register.
module ex_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en,
    input  logic        flush,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        regWrite,
    input  logic        wDataSrc,
    input  logic        aluSrc,
    input  logic        MemtoReg,
    input  logic        branch,
    input  logic        branchSel,
    input  logic        HALT,
    input  logic        datomic,
    input  logic [1:0]  PCSel,
    input  aluop_t      ALUop,
    input  logic [31:0] Imm,
    input  logic [31:0] pcp4,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    input  logic [25:0] JumpAddr,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  wsel,
    input  logic        mem_regWrite,
    input  logic        wb_regWrite,
    input  logic [4:0]  mem_wsel,
    input  logic [4:0]  wb_wsel,
    input  logic [31:0] mem_wdat,
    input  logic [31:0] wb_wdat,
    output logic        redirect,
    output logic [31:0] target,
    output logic        exmem_dREN,
    output logic        exmem_dWEN,
    output logic        exmem_regWrite,
    output logic        exmem_MemtoReg,
    output logic        exmem_datomic,
    output logic        exmem_halt,
    output logic [31:0] exmem_result,
    output logic [31:0] exmem_store,
    output logic [31:0] exmem_pcp4,
    output logic [4:0]  exmem_wsel
);

    pcsel_t pcSel;
    word_t  fwdA;
    word_t  fwdB;
    word_t  opB;
    word_t  aluOut;
    word_t  result;
    word_t  brTarget;
    logic   aluZero;
    logic   cmpZero;

    assign pcSel = pcsel_t'(PCSel);

    always_comb begin
        fwdA = rdat1;
        if (mem_regWrite && (mem_wsel == rs) && (rs != '0)) begin
            fwdA = mem_wdat;
        end else if (wb_regWrite && (wb_wsel == rs) && (rs != '0)) begin
            fwdA = wb_wdat;
        end
    end

    always_comb begin
        fwdB = rdat2;
        if (mem_regWrite && (mem_wsel == rt) && (rt != '0)) begin
            fwdB = mem_wdat;
        end else if (wb_regWrite && (wb_wsel == rt) && (rt != '0)) begin
            fwdB = wb_wdat;
        end
    end

    assign opB = aluSrc ? Imm : fwdB;

    ex_alu uAlu (
        .opA   (fwdA),
        .opB   (opB),
        .ALUop (ALUop),
        .out   (aluOut),
        .zero  (aluZero)
    );

    assign result   = wDataSrc ? pcp4 : aluOut;
    assign brTarget = pcp4 + (Imm << 2);

    // Reuse the ALU subtractor when it is already computing fwdA-fwdB.
    assign cmpZero = ((ALUop == ALU_SUB) && !aluSrc) ? aluZero : (fwdA == fwdB);

    always_comb begin
        redirect = 1'b0;
        target   = pcp4;
        case (pcSel)
            PC_BR: begin
                if (branch && (branchSel ? !cmpZero : cmpZero)) begin
                    redirect = 1'b1;
                    target   = brTarget;
                end
            end
            PC_J: begin
                redirect = 1'b1;
                target   = {pcp4[31:28], JumpAddr, 2'b00};
            end
            PC_JR: begin
                redirect = 1'b1;
                target   = fwdA;
            end
            default: begin
                redirect = 1'b0;
                target   = pcp4;
            end
        endcase
    end

    // Halt is sticky: once latched only reset releases the register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exmem_dREN     <= 1'b0;
            exmem_dWEN     <= 1'b0;
            exmem_regWrite <= 1'b0;
            exmem_MemtoReg <= 1'b0;
            exmem_datomic  <= 1'b0;
            exmem_halt     <= 1'b0;
            exmem_result   <= '0;
            exmem_store    <= '0;
            exmem_pcp4     <= '0;
            exmem_wsel     <= '0;
        end else if (exmem_halt) begin
            exmem_halt     <= 1'b1;
        end else if (flush) begin
            exmem_dREN     <= 1'b0;
            exmem_dWEN     <= 1'b0;
            exmem_regWrite <= 1'b0;
            exmem_MemtoReg <= 1'b0;
            exmem_datomic  <= 1'b0;
            exmem_halt     <= 1'b0;
            exmem_result   <= '0;
            exmem_store    <= '0;
            exmem_pcp4     <= '0;
            exmem_wsel     <= '0;
        end else if (en) begin
            exmem_dREN     <= dREN;
            exmem_dWEN     <= dWEN;
            exmem_regWrite <= regWrite;
            exmem_MemtoReg <= MemtoReg;
            exmem_datomic  <= datomic;
            exmem_halt     <= HALT;
            exmem_result   <= result;
            exmem_store    <= fwdB;
            exmem_pcp4     <= pcp4;
            exmem_wsel     <= wsel;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases plus random traffic against a behavioural model.
module tb_ex_stage;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        dREN;
        logic        dWEN;
        logic        regWrite;
        logic        MemtoReg;
        logic        datomic;
        logic        halt;
        logic [31:0] result;
        logic [31:0] store;
        logic [31:0] pcp4;
        logic [4:0]  wsel;
    } exm_t;

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        exm_t        exm;
    } item_t;

    logic        CLK, nRST, en, flush;
    logic        dREN, dWEN, regWrite, wDataSrc, aluSrc, MemtoReg, branch, branchSel, HALT, datomic;
    logic [1:0]  PCSel;
    aluop_t      ALUop;
    logic [31:0] Imm, pcp4, rdat1, rdat2;
    logic [25:0] JumpAddr;
    logic [4:0]  rs, rt, wsel;
    logic        mem_regWrite, wb_regWrite;
    logic [4:0]  mem_wsel, wb_wsel;
    logic [31:0] mem_wdat, wb_wdat;
    logic        redirect;
    logic [31:0] target;
    logic        exmem_dREN, exmem_dWEN, exmem_regWrite, exmem_MemtoReg, exmem_datomic, exmem_halt;
    logic [31:0] exmem_result, exmem_store, exmem_pcp4;
    logic [4:0]  exmem_wsel;

    int checks = 0;
    int errors = 0;
    item_t sbq[$];
    exm_t mdl;
    aluop_t aluOps[10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                           ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

    ex_stage dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .dREN(dREN), .dWEN(dWEN), .regWrite(regWrite), .wDataSrc(wDataSrc),
        .aluSrc(aluSrc), .MemtoReg(MemtoReg), .branch(branch), .branchSel(branchSel),
        .HALT(HALT), .datomic(datomic), .PCSel(PCSel), .ALUop(ALUop),
        .Imm(Imm), .pcp4(pcp4), .rdat1(rdat1), .rdat2(rdat2), .JumpAddr(JumpAddr),
        .rs(rs), .rt(rt), .wsel(wsel),
        .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .mem_wsel(mem_wsel), .wb_wsel(wb_wsel), .mem_wdat(mem_wdat), .wb_wdat(wb_wdat),
        .redirect(redirect), .target(target),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_regWrite(exmem_regWrite),
        .exmem_MemtoReg(exmem_MemtoReg), .exmem_datomic(exmem_datomic), .exmem_halt(exmem_halt),
        .exmem_result(exmem_result), .exmem_store(exmem_store), .exmem_pcp4(exmem_pcp4),
        .exmem_wsel(exmem_wsel)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic exm_t dutExm();
        return '{exmem_dREN, exmem_dWEN, exmem_regWrite, exmem_MemtoReg, exmem_datomic,
                 exmem_halt, exmem_result, exmem_store, exmem_pcp4, exmem_wsel};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: values worked out from the stage's architectural rules.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (mem_regWrite && mem_wsel == r) return mem_wdat;
        if (wb_regWrite && wb_wsel == r) return wb_wdat;
        return rf;
    endfunction

    function automatic logic [31:0] aluRef(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic step();
        item_t it;
        logic [31:0] a, b, res;
        a = fwd(rs, rdat1);
        b = fwd(rt, rdat2);
        res = wDataSrc ? pcp4 : aluRef(ALUop, a, aluSrc ? Imm : b);
        it.redir = 1'b0;
        it.tgt = pcp4;
        if (PCSel == 2'b01 && branch && (branchSel ? (a != b) : (a == b))) begin
            it.redir = 1'b1;
            it.tgt = pcp4 + Imm * 4;
        end else if (PCSel == 2'b10) begin
            it.redir = 1'b1;
            it.tgt = (pcp4 & 32'hF000_0000) + {4'b0, JumpAddr, 2'b00};
        end else if (PCSel == 2'b11) begin
            it.redir = 1'b1;
            it.tgt = a;
        end
        if (!mdl.halt) begin
            if (flush) mdl = '0;
            else if (en) mdl = '{dREN, dWEN, regWrite, MemtoReg, datomic, HALT, res, b, pcp4, wsel};
        end
        it.exm = mdl;
        sbq.push_back(it);
        @(negedge CLK);
    endtask

    // Monitor: redirect/target sampled before the edge, EX/MEM just after it.
    initial begin
        item_t it;
        logic r;
        logic [31:0] t;
        forever begin
            @(posedge CLK);
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                r = redirect;
                t = target;
                chk("sb_redirect", 128'(r), 128'(it.redir));
                chk("sb_target", 128'(t), 128'(it.tgt));
                #1;
                chk("sb_exmem", 128'(dutExm()), 128'(it.exm));
            end
        end
    end

    task automatic clearIns();
        en = 0; flush = 0; dREN = 0; dWEN = 0; regWrite = 0; wDataSrc = 0; aluSrc = 0;
        MemtoReg = 0; branch = 0; branchSel = 0; HALT = 0; datomic = 0; PCSel = 2'b00;
        ALUop = ALU_ADD; Imm = 0; pcp4 = 0; rdat1 = 0; rdat2 = 0; JumpAddr = 0;
        rs = 0; rt = 0; wsel = 0; mem_regWrite = 0; wb_regWrite = 0;
        mem_wsel = 0; wb_wsel = 0; mem_wdat = 0; wb_wdat = 0;
    endtask

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    task automatic rndIns();
        en = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 9) == 0);
        {dREN, dWEN, regWrite, wDataSrc, aluSrc, MemtoReg, branch, branchSel, datomic} = 9'($urandom);
        HALT = 1'b0;
        PCSel = 2'($urandom);
        ALUop = aluOps[$urandom_range(0, 9)];
        Imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        pcp4 = $urandom & 32'hFFFF_FFFC;
        rdat1 = $urandom;
        rdat2 = ($urandom_range(0, 3) == 0) ? rdat1 : $urandom;
        JumpAddr = 26'($urandom);
        rs = pickReg(); rt = pickReg(); wsel = pickReg();
        mem_regWrite = 1'($urandom); wb_regWrite = 1'($urandom);
        mem_wsel = pickReg(); wb_wsel = pickReg();
        mem_wdat = $urandom; wb_wdat = $urandom;
    endtask

    task automatic drainSb();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge CLK);
        chk("sb_drained", 128'(sbq.size()), 128'(0));
    endtask

    initial begin
        clearIns();
        mdl = '0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_exmem", 128'(dutExm()), 128'(0));
        nRST = 1'b1;

        // MEM result wins over WB for the same register.
        clearIns();
        rs = 5; rdat1 = 1; rt = 6; rdat2 = 3;
        mem_regWrite = 1; mem_wsel = 5; mem_wdat = 10;
        wb_regWrite = 1; wb_wsel = 5; wb_wdat = 99;
        en = 1; regWrite = 1; wsel = 8;
        step();
        chk("mem_priority", 128'(exmem_result), 128'(13));

        // $0 is never forwarded.
        clearIns();
        mem_regWrite = 1; mem_wsel = 0; mem_wdat = 7;
        aluSrc = 1; Imm = 2; en = 1;
        step();
        chk("zero_reg", 128'(exmem_result), 128'(2));

        // BNE taken, then not taken.
        clearIns();
        rs = 1; rdat1 = 4; rt = 2; rdat2 = 7; pcp4 = 32'h100; Imm = 3;
        PCSel = 2'b01; branch = 1; branchSel = 1; ALUop = ALU_SUB;
        #1;
        chk("bne_taken_redir", 128'(redirect), 128'(1));
        chk("bne_taken_tgt", 128'(target), 128'(32'h10C));
        step();
        rdat1 = 7;
        #1;
        chk("bne_not_redir", 128'(redirect), 128'(0));
        chk("bne_not_tgt", 128'(target), 128'(32'h100));
        step();

        // JR through WB forward, J target, JAL link value.
        clearIns();
        rs = 31; rdat1 = 32'h55; wb_regWrite = 1; wb_wsel = 31; wb_wdat = 32'h2000; PCSel = 2'b11;
        #1;
        chk("jr_redir", 128'(redirect), 128'(1));
        chk("jr_tgt", 128'(target), 128'(32'h2000));
        step();
        clearIns();
        PCSel = 2'b10; pcp4 = 32'h44; JumpAddr = 26'h10; wDataSrc = 1; regWrite = 1; wsel = 31; en = 1;
        #1;
        chk("jal_tgt", 128'(target), 128'(32'h40));
        step();
        chk("jal_link", 128'(exmem_result), 128'(32'h44));

        // Stall holds, flush with en=0 loads a bubble.
        clearIns();
        rs = 1; rdat1 = 20; rt = 2; rdat2 = 22; regWrite = 1; dREN = 1; dWEN = 1; wsel = 9; en = 1;
        step();
        chk("stall_load", 128'(exmem_result), 128'(42));
        en = 0;
        for (int i = 0; i < 3; i++) begin
            rdat1 = $urandom; rdat2 = $urandom;
            step();
        end
        chk("stall_hold", 128'(exmem_result), 128'(42));
        chk("stall_hold_rw", 128'(exmem_regWrite), 128'(1));
        flush = 1;
        step();
        chk("flush_ctrl", 128'({exmem_regWrite, exmem_dWEN, exmem_dREN}), 128'(0));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rndIns();
            step();
        end

        // Sticky halt followed by further activity.
        clearIns();
        rs = 1; rdat1 = 5; rt = 2; rdat2 = 6; HALT = 1; en = 1; regWrite = 1; wsel = 4;
        step();
        chk("halt_set", 128'(exmem_halt), 128'(1));
        chk("halt_result", 128'(exmem_result), 128'(11));
        for (int i = 0; i < 20; i++) begin
            rndIns();
            en = 1;
            HALT = 1'($urandom);
            step();
        end
        chk("halt_frozen", 128'(exmem_result), 128'(11));
        drainSb();

        // Asynchronous reset between edges while halted.
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        chk("async_reset", 128'(dutExm()), 128'(0));
        @(negedge CLK);
        chk("reset_hold", 128'(dutExm()), 128'(0));
        mdl = '0;
        nRST = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rndIns();
            step();
        end
        drainSb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
